// File: rtl/foh_interp_stream_if.sv
// Stream bundle for foh_interp_stream: input frame handshake plus interpolated output handshake.
// The slave modport is the interpolator's view; the master modport is the source/sink side.
interface foh_interp_stream_if #(
  parameter int DW         = 16,
  parameter int LOG2_RATIO = 4,
  parameter int CH         = 2
);
  logic                  in_valid;
  logic                  in_ready;
  logic [CH*DW-1:0]      in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [CH*DW-1:0]      out_data;
  logic [LOG2_RATIO-1:0] out_phase;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_phase
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_phase
  );
endinterface

// File: rtl/foh_interp_stream.sv
// First-order-hold upsampler: emits 2^LOG2_RATIO linear steps from the previous to the current frame.
// Define FOH_ROUND_EN for round-half-up interpolation instead of truncation toward -inf.
module foh_interp_stream #(
  parameter int DW         = 16,
  parameter int LOG2_RATIO = 4,
  parameter int CH         = 2
) (
  input  logic                clk,
  input  logic                rst,
  foh_interp_stream_if.slave  bus
);
  localparam int DDW = DW + 1;
  localparam int AW  = DW + 1 + LOG2_RATIO;

`ifdef FOH_ROUND_EN
  localparam logic signed [AW-1:0] ROUND_BIAS = AW'(1) << (LOG2_RATIO - 1);
`else
  localparam logic signed [AW-1:0] ROUND_BIAS = '0;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_nxt;

  logic        [DW-1:0]         in_x   [CH];
  logic signed [DW-1:0]         a_q    [CH];
  logic signed [DW-1:0]         b_q    [CH];
  logic signed [DDW-1:0]        d_q    [CH];
  logic signed [AW-1:0]         acc_q  [CH];
  logic signed [AW-1:0]         step   [CH];
  logic signed [AW-1:0]         interp [CH];
  logic        [LOG2_RATIO-1:0] k_q;

  logic                  last_phase;
  logic                  in_ready_c;
  logic                  out_valid_c;
  logic                  in_accept;
  logic                  out_accept;
  logic [CH*DW-1:0]      out_data_c;

  assign last_phase = &k_q;
  assign in_accept  = bus.in_valid & in_ready_c;
  assign out_accept = out_valid_c & bus.out_ready;

  always_comb begin
    for (int ch = 0; ch < CH; ch++) begin
      in_x[ch] = bus.in_data[ch*DW +: DW];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: default assignment first in every combinational block keeps it latch-free.
    state_nxt = state;
    case (state)
      IDLE:    if (in_accept) state_nxt = RUN;
      RUN:     if (out_accept && last_phase && !in_accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The last output of an interval can hand over to the next frame in the same cycle.
  always_comb begin
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state)
      IDLE: in_ready_c = 1'b1;
      RUN: begin
        out_valid_c = 1'b1;
        in_ready_c  = last_phase & bus.out_ready;
      end
      default: ;
    endcase
  end

  // NOTE: the per-channel register arrays are small and the reset must clear them, so they are reset explicitly.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_q <= '0;
      for (int ch = 0; ch < CH; ch++) begin
        a_q[ch]   <= '0;
        b_q[ch]   <= '0;
        d_q[ch]   <= '0;
        acc_q[ch] <= '0;
      end
    end else if (in_accept) begin
      k_q <= '0;
      for (int ch = 0; ch < CH; ch++) begin
        a_q[ch]   <= b_q[ch];
        b_q[ch]   <= in_x[ch];
        d_q[ch]   <= {in_x[ch][DW-1], in_x[ch]} - {b_q[ch][DW-1], b_q[ch]};
        acc_q[ch] <= '0;
      end
    end else if (out_accept && !last_phase) begin
      k_q <= k_q + LOG2_RATIO'(1);
      for (int ch = 0; ch < CH; ch++) begin
        acc_q[ch] <= acc_q[ch] + {{LOG2_RATIO{d_q[ch][DDW-1]}}, d_q[ch]};
      end
    end
  end

  // ACC holds k*D; dividing by RATIO and adding A always lands between A and B, so DW bits suffice.
  always_comb begin
    out_data_c = '0;
    for (int ch = 0; ch < CH; ch++) begin
      step[ch]   = (acc_q[ch] + ROUND_BIAS) >>> LOG2_RATIO;
      interp[ch] = {{(AW-DW){a_q[ch][DW-1]}}, a_q[ch]} + step[ch];
      if (state == RUN) out_data_c[ch*DW +: DW] = interp[ch][DW-1:0];
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = out_data_c;
  assign bus.out_phase = k_q;
endmodule

// File: tb/tb_foh_interp_stream.sv
// Self-checking bench for foh_interp_stream: directed scenarios plus random traffic,
// compared cycle by cycle against a queue of expected frames computed by exact floor division.
module tb_foh_interp_stream;
  localparam int DW         = 16;
  localparam int LOG2_RATIO = 4;
  localparam int CH         = 2;
  localparam int RATIO      = 1 << LOG2_RATIO;
`ifdef FOH_ROUND_EN
  localparam int BIAS = RATIO / 2;
`else
  localparam int BIAS = 0;
`endif

  typedef logic [CH*DW-1:0] frame_t;
  typedef struct {
    frame_t data;
    int     k;
  } exp_t;

  logic clk;
  logic rst;
  int   passed;
  int   failed;
  int   total;

  exp_t exp_q[$];
  int   prev[CH];

  foh_interp_stream_if #(.DW(DW), .LOG2_RATIO(LOG2_RATIO), .CH(CH)) bus ();

  foh_interp_stream #(.DW(DW), .LOG2_RATIO(LOG2_RATIO), .CH(CH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      failed = failed + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int floor_div(input int n, input int d);
    int q;
    q = n / d;
    if ((n % d != 0) && (n < 0)) q = q - 1;
    return q;
  endfunction

  function automatic frame_t mk(input logic [DW-1:0] c0, input logic [DW-1:0] c1);
    return {c1, c0};
  endfunction

  // Queue all RATIO outputs of the interval from the previous sample to x.
  task automatic push_frame(input frame_t x);
    int   xs [CH];
    int   v;
    exp_t e;
    for (int ch = 0; ch < CH; ch++) xs[ch] = $signed(x[ch*DW +: DW]);
    for (int k = 0; k < RATIO; k++) begin
      e.data = '0;
      e.k    = k;
      for (int ch = 0; ch < CH; ch++) begin
        v = prev[ch] + floor_div(k * (xs[ch] - prev[ch]) + BIAS, RATIO);
        e.data[ch*DW +: DW] = v[DW-1:0];
      end
      exp_q.push_back(e);
    end
    for (int ch = 0; ch < CH; ch++) prev[ch] = xs[ch];
  endtask

  task automatic cycle(input logic iv, input frame_t din, input logic ordy);
    logic exp_valid;
    logic exp_ready;
    bus.in_valid  = iv;
    bus.in_data   = din;
    bus.out_ready = ordy;
    #1;
    exp_valid = (exp_q.size() > 0);
    exp_ready = !exp_valid || (exp_q.size() == 1 && ordy);
    check("out_valid", 64'(bus.out_valid), 64'(exp_valid));
    check("in_ready", 64'(bus.in_ready), 64'(exp_ready));
    if (exp_valid) begin
      check("out_data", 64'(bus.out_data), 64'(exp_q[0].data));
      check("out_phase", 64'(bus.out_phase), 64'(exp_q[0].k));
    end
    if (exp_valid && ordy) void'(exp_q.pop_front());
    if (iv && exp_ready) push_frame(din);
    @(negedge clk);
  endtask

  task automatic run(input int n, input logic iv, input logic ordy);
    frame_t d;
    for (int i = 0; i < n; i++) begin
      d = frame_t'($urandom());
      cycle(iv, d, ordy);
    end
  endtask

  task automatic send(input frame_t x);
    cycle(1'b1, x, 1'b1);
  endtask

  task automatic do_reset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", 64'(bus.in_ready), 64'(1));
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_out_data", 64'(bus.out_data), 64'(0));
    check("rst_out_phase", 64'(bus.out_phase), 64'(0));
    exp_q.delete();
    for (int ch = 0; ch < CH; ch++) prev[ch] = 0;
  endtask

  initial begin
    passed = 0;
    failed = 0;
    total  = 0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    for (int ch = 0; ch < CH; ch++) prev[ch] = 0;
    @(negedge clk);
    do_reset();

    // Ramp from 0 to 0x0100 on ch0, ch1 flat.
    send(mk(16'h0100, 16'h0000));
    run(15, 1'b0, 1'b1);
    check("ramp_k15_ch0", 64'(bus.out_data[DW-1:0]), 64'(16'h00F0));
    run(3, 1'b0, 1'b1);

    // Negative slope 0x0100 -> 0xFF00.
    send(mk(16'hFF00, 16'h1234));
    run(15, 1'b0, 1'b1);
    check("neg_k15_ch0", 64'(bus.out_data[DW-1:0]), 64'(16'hFF20));
    run(3, 1'b0, 1'b1);

    // Full-scale swing 0x7FFF -> 0x8000.
    send(mk(16'h7FFF, 16'h8000));
    run(18, 1'b0, 1'b1);
    send(mk(16'h8000, 16'h7FFF));
    run(15, 1'b0, 1'b1);
`ifdef FOH_ROUND_EN
    check("ext_k15_ch0", 64'(bus.out_data[DW-1:0]), 64'(16'h9000));
`else
    check("ext_k15_ch0", 64'(bus.out_data[DW-1:0]), 64'(16'h8FFF));
`endif
    run(3, 1'b0, 1'b1);

    // Sub-LSB slope 0 -> 1 exercises the rounding rule.
    send(mk(16'h0000, 16'h0000));
    run(18, 1'b0, 1'b1);
    send(mk(16'h0001, 16'hFFFF));
    run(8, 1'b0, 1'b1);
`ifdef FOH_ROUND_EN
    check("rnd_k8_ch0", 64'(bus.out_data[DW-1:0]), 64'(16'h0001));
`else
    check("rnd_k8_ch0", 64'(bus.out_data[DW-1:0]), 64'(16'h0000));
`endif
    run(10, 1'b0, 1'b1);

    // Back-pressure at k=5 with a competing in_valid that must be ignored.
    send(frame_t'($urandom()));
    run(5, 1'b0, 1'b1);
    run(3, 1'b1, 1'b0);
    run(13, 1'b0, 1'b1);

    // Continuous in_valid: outputs must stream without gaps across intervals.
    run(50, 1'b1, 1'b1);
    run(20, 1'b0, 1'b1);

    // Reset in the middle of an interval at k=7.
    send(frame_t'($urandom()));
    run(7, 1'b0, 1'b1);
    check("pre_rst_phase", 64'(bus.out_phase), 64'(7));
    do_reset();
    run(2, 1'b0, 1'b1);

    // Random traffic on both handshakes.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 3) != 0), frame_t'($urandom()), ($urandom_range(0, 3) != 0));
    end
    run(40, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
